// File: rtl/fir4_mac.sv
// Sequential 4-tap FIR MAC: snapshots taps and coefficients on start, one shared multiplier over 4 cycles.
// Latency: start at E0 -> y_valid one cycle after E5. Starts and coefficient writes are ignored while busy.
module fir4_mac #(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int ACC_W     = 19,
    parameter int OUT_SHIFT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] x0,
    input  logic [DATA_W-1:0] x1,
    input  logic [DATA_W-1:0] x2,
    input  logic [DATA_W-1:0] x3,
    input  logic              coef_we,
    input  logic [1:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_wdata,
    output logic              busy,
    output logic              y_valid,
    output logic [ACC_W-1:0]  y,
    output logic [DATA_W-1:0] y_sat
);

    localparam int PROD_W = DATA_W + COEF_W + 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << DATA_W) - 1);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                   state_q, state_d;
    logic [DATA_W-1:0]        samp_q  [4];
    logic [DATA_W-1:0]        samp_d  [4];
    logic signed [COEF_W-1:0] coef_q  [4];
    logic signed [COEF_W-1:0] coef_d  [4];
    logic signed [COEF_W-1:0] ksnap_q [4];
    logic signed [COEF_W-1:0] ksnap_d [4];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [1:0]               idx_q, idx_d;
    logic                     busy_q, busy_d;
    logic                     y_valid_q, y_valid_d;
    logic signed [ACC_W-1:0]  y_q, y_d;
    logic [DATA_W-1:0]        y_sat_q, y_sat_d;

    logic [DATA_W-1:0]        samp_sel;
    logic signed [COEF_W-1:0] coef_sel;
    logic signed [PROD_W-1:0] samp_ext, coef_ext, prod;
    logic signed [ACC_W-1:0]  prod_acc, shifted;
    logic [DATA_W-1:0]        sat_val;

    // Samples are unsigned, so they get a zero sign bit before the signed multiply.
    always_comb begin
        samp_sel = samp_q[idx_q];
        coef_sel = ksnap_q[idx_q];
        samp_ext = $signed({{(PROD_W-DATA_W){1'b0}}, samp_sel});
        coef_ext = $signed({{(PROD_W-COEF_W){coef_sel[COEF_W-1]}}, coef_sel});
        prod     = samp_ext * coef_ext;
        prod_acc = $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});
        shifted  = acc_q >>> OUT_SHIFT;
        if (shifted < 0) begin
            sat_val = '0;
        end else if (shifted > SAT_MAX) begin
            sat_val = '1;
        end else begin
            sat_val = shifted[DATA_W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        samp_d    = samp_q;
        coef_d    = coef_q;
        ksnap_d   = ksnap_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        y_valid_d = 1'b0;
        y_d       = y_q;
        y_sat_d   = y_sat_q;
        unique case (state_q)
            IDLE: begin
                if (coef_we) begin
                    coef_d[coef_addr] = coef_wdata;
                end
                // Coefficients are captured before this edge's write lands, so a
                // simultaneous write only affects the next computation.
                if (start) begin
                    samp_d[0] = x0;
                    samp_d[1] = x1;
                    samp_d[2] = x2;
                    samp_d[3] = x3;
                    ksnap_d   = coef_q;
                    acc_d     = '0;
                    idx_d     = 2'd0;
                    busy_d    = 1'b1;
                    state_d   = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + prod_acc;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                y_d       = acc_q;
                y_sat_d   = sat_val;
                y_valid_d = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            idx_q     <= 2'd0;
            busy_q    <= 1'b0;
            y_valid_q <= 1'b0;
            y_q       <= '0;
            y_sat_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                samp_q[i]  <= '0;
                ksnap_q[i] <= '0;
                coef_q[i]  <= (i == 0) ? COEF_W'(1) : '0;
            end
        end else begin
            state_q   <= state_d;
            samp_q    <= samp_d;
            coef_q    <= coef_d;
            ksnap_q   <= ksnap_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            y_valid_q <= y_valid_d;
            y_q       <= y_d;
            y_sat_q   <= y_sat_d;
        end
    end

    assign busy    = busy_q;
    assign y_valid = y_valid_q;
    assign y       = y_q;
    assign y_sat   = y_sat_q;

endmodule

// File: doc/fir4_mac.md
Name: fir4_mac

Overview:
- Sequential 4-tap FIR multiply-accumulate stage that sits directly downstream of the 4-tap sample delay line.
- On a start pulse it snapshots taps x0..x3 and runs one shared multiplier over 4 cycles against 4 programmable signed coefficients.
- Produces a full-precision signed result and a shifted, saturated 8-bit sample.
- The snapshot isolates the computation from the delay line shifting during the MAC sequence.

Parameters:
- DATA_W, 8: sample width; samples are unsigned.
- COEF_W, 8: coefficient width; coefficients are signed two's complement.
- ACC_W, 19: accumulator/result width, signed. Must be at least DATA_W+COEF_W+3.
- OUT_SHIFT, 0: arithmetic right shift applied to the accumulator before saturation to y_sat.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a filter computation on current x0..x3
- x0  input  DATA_W  newest tap
- x1  input  DATA_W  tap 1
- x2  input  DATA_W  tap 2
- x3  input  DATA_W  oldest tap
- coef_we  input  1  coefficient write strobe
- coef_addr  input  2  coefficient index 0..3
- coef_wdata  input  COEF_W  coefficient value
- busy  output  1  high while a computation is in progress
- y_valid  output  1  one-cycle pulse: y and y_sat updated
- y  output  ACC_W  signed full-precision result
- y_sat  output  DATA_W  result >>> OUT_SHIFT, saturated to 0..2^DATA_W-1

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; busy=0, y_valid=0, y=0, y_sat=0.
  - Accumulator, tap index and snapshot registers cleared.
  - Coefficients reset to c0=1, c1=c2=c3=0, so the default filter is identity on x0.
- Reset mid-computation aborts it: no y_valid is produced, and coefficients return to their defaults.
- States: IDLE, MAC, DONE.
- IDLE:
  - If start is sampled high at edge E0: snapshot x0..x3, clear the accumulator, set idx=0, go to MAC.
  - busy=1 from E0.
- MAC:
  - At each edge E1..E4: acc <= acc + s[idx]*c[idx], where s[idx] is zero-extended to DATA_W+1 bits signed.
  - idx increments each cycle; after the idx=3 accumulate (E4), go to DONE.
- DONE:
  - At E5: y <= acc; y_sat <= sat(acc >>> OUT_SHIFT); y_valid <= 1 for exactly one cycle; busy <= 0; go to IDLE.
- Latency: start sampled at E0 → y_valid high in the cycle after E5. Throughput is one result per 6 cycles.
- Saturation: a negative shifted value gives 0; a value above 2^DATA_W-1 gives 2^DATA_W-1; otherwise the low DATA_W bits.
- y and y_sat hold their values until the next DONE.
- start while busy=1 (MAC/DONE states, including the E5 cycle itself) is ignored and not queued.
- start sampled in the cycle y_valid is high is accepted, since the state is IDLE.
- Coefficient writes:
  - coef_we in IDLE writes c[coef_addr] <= coef_wdata at the clock edge.
  - A write and a start on the same edge: the computation uses the old coefficient value; the new value applies from the next start.
  - coef_we while busy=1 is ignored; coefficients are frozen for the whole computation.
- Accumulator never overflows at the default widths: range ±4·255·128 fits in 19 bits signed.

Test Plan:
- After reset, set x0=200, x1=x2=x3=55, pulse start → y_valid pulses once, 6 edges after start; y=200, y_sat=200. busy is high for exactly 5 cycles.
- Write c=1,2,3,4; x0..x3=10,20,30,40; start → y=300, y_sat=255 (saturated).
- Write c=-1,0,0,0; x0=100; start → y=-100 (19-bit two's complement), y_sat=0. Then write all c=-128 with all x=255 → y=-130560.
- Change x0..x3 on every cycle during MAC → y still reflects the snapshot from the start edge. A second start pulse and coef_we during busy → no second result, and the coefficients are unchanged (checked by a following computation).
- Assert rst_n low at E3 of a computation → busy=0, y=0, no y_valid. The next computation with x0=7 gives y=7 (default coefficients).
- Hold start high continuously with constant taps → y_valid every 6 cycles with identical y. Also check coef_we and start on the same edge use the old coefficient.
